// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multicycle main control unit for the 16-bit MIPS-style core. Walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath
// strobes from the state register. Also provides a memory wait-state
// handshake with a bus watchdog, and a retired-instruction counter.
//
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN
//   defined   : illegal opcode in DECODE -> TRAP, sticky illegal_op set
//   undefined : illegal opcode is retired as a NOP, illegal_op tied 0
//
// Parameters
//   WAIT_LIMIT  max consecutive wait cycles in a memory state before bus_err
//   CNT_W       width of the retired-instruction counter
//
// Ports
//   clk, rst_n          clock (posedge), asynchronous active-low reset
//   opcode[3:0]         instr[15:12], sampled in DECODE
//   mem_ready           memory access completes this cycle
//   PCWrite..PCSource   datapath strobes (Moore, except FETCH IRWrite/PCWrite)
//   halted              core stopped (HALT or TRAP state)
//   bus_err             sticky, watchdog expired
//   illegal_op          sticky, illegal opcode trapped
//   state[3:0]          current state encoding (debug)
//   retired[CNT_W-1:0]  completed instructions, wraps to 0
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             halted,
    output logic             bus_err,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_R_WB     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    localparam int             WC_W     = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(WAIT_LIMIT);

    state_t          state_r, next_state;
    logic [WC_W-1:0] wait_cnt, wait_cnt_next;
    logic            is_lw;          // remembers LW vs SW from DECODE for MEM_ADDR
    logic            retire;
    logic            bus_err_set;
    logic            wait_state;
    logic            illegal_set;

    assign state      = state_r;
    assign wait_state = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        next_state  = state_r;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        halted      = 1'b0;
        retire      = 1'b0;
        bus_err_set = 1'b0;
        illegal_set = 1'b0;

        case (state_r)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC load only when the fetched word is actually valid.
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;   // precompute branch target into ALUOut
                case (opcode)
                    4'h0, 4'h1, 4'h2, 4'h3: next_state = S_EXEC_R;
                    4'h4:                   next_state = S_EXEC_I;
                    4'h5, 4'h6:             next_state = S_MEM_ADDR;
                    4'h7:                   next_state = S_BRANCH;
                    4'h8:                   next_state = S_JUMP;
                    4'hF:                   next_state = S_HALT;
                    default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                        next_state  = S_TRAP;
                        illegal_set = 1'b1;
`else
                        next_state  = S_FETCH;
                        retire      = 1'b1;
`endif
                    end
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b10;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_EXEC_I: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = S_I_WB;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    next_state = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                next_state  = S_FETCH;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT, S_TRAP: halted = 1'b1;
            default:        next_state = S_IDLE;
        endcase

        // Watchdog: a ready in the last allowed cycle still wins.
        if (wait_state && !mem_ready && (wait_cnt == WAIT_MAX)) begin
            next_state  = S_HALT;
            bus_err_set = 1'b1;
        end

        // Clear on entry into a wait state or on ready; count while stalled.
        wait_cnt_next = wait_cnt;
        if ((next_state != state_r) &&
            (next_state == S_FETCH || next_state == S_MEM_RD || next_state == S_MEM_WR))
            wait_cnt_next = '0;
        else if (wait_state && mem_ready)
            wait_cnt_next = '0;
        else if (wait_state && (next_state == state_r))
            wait_cnt_next = wait_cnt + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
            bus_err  <= 1'b0;
            is_lw    <= 1'b0;
        end else begin
            state_r  <= next_state;
            wait_cnt <= wait_cnt_next;
            if (retire)      retired <= retired + 1'b1;
            if (bus_err_set) bus_err <= 1'b1;
            if (state_r == S_DECODE) is_lw <= (opcode == 4'h5);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           illegal_op <= 1'b0;
        else if (illegal_set) illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule
